// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the register-file RAM write port. Round-robin
// arbitration between requester A (ALU writeback) and requester B (load
// path), with a full zero-scrub of the RAM after reset and on clear_req.
module rf_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  busy
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  last_grant_b;
  logic                  a_acc;
  logic                  b_acc;

  assign a_acc = a_valid && a_ready;
  assign b_acc = b_valid && b_ready;

  // State register; reset always lands in CLEAR so the scrub restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, busy and round-robin grant (ready may depend on valid).
  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    busy      = 1'b1;
    case (state)
      CLEAR: begin
        if (clr_cnt == LAST_ADDR) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b0;
        if (clear_req) begin
          state_nxt = CLEAR;
        end else begin
          // Contention goes to whichever requester was not granted last.
          a_ready = a_valid && (!b_valid || last_grant_b);
          b_ready = b_valid && (!a_valid || !last_grant_b);
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Registered RAM write port, scrub counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt      <= '0;
      ram_wr_en    <= 1'b0;
      ram_wr_addr  <= '0;
      ram_din      <= '0;
      last_grant_b <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          ram_wr_en   <= 1'b1;
          ram_wr_addr <= clr_cnt;
          ram_din     <= '0;
          clr_cnt     <= ADDR_WIDTH'(clr_cnt + 1'b1);
        end
        RUN: begin
          clr_cnt <= '0;
          if (a_acc) begin
            ram_wr_en    <= 1'b1;
            ram_wr_addr  <= a_addr;
            ram_din      <= a_data;
            last_grant_b <= 1'b0;
          end else if (b_acc) begin
            ram_wr_en    <= 1'b1;
            ram_wr_addr  <= b_addr;
            ram_din      <= b_data;
            last_grant_b <= 1'b1;
          end else begin
            // Address and data hold; only the enable drops.
            ram_wr_en <= 1'b0;
          end
        end
        default: begin
          ram_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
